bcd2f32: RTL and testbench

Sequential BCD-to-IEEE754 float32 converter, the inverse of the float32-to-BCD display path. It accepts a signed fixed-point decimal digit vector in the same digit layout the encoder produces. Digit index RADIX holds the separator; indices above it are integer digits and indices below it are fraction digits. It returns a round-to-nearest-even float32 through a start/done handshake. It sits between keypad/BCD entry logic and the float datapath.

---
 rtl/bcd2f32.sv | 250 +++++++++++++++++++++++++
 tb/tb_bcd2f32.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bcd2f32.sv
// bcd2f32: sequential signed fixed-point BCD to float32 converter.
// Integer digits are folded binary MSB-first, fraction digits are turned into
// binary by repeated decimal doubling, then the value is normalised and rounded
// to nearest-even.
module bcd2f32 #(
   parameter int unsigned DIGITS = 10,
   parameter int unsigned RADIX  = 8,
   parameter int unsigned FBITS  = 56
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  sign,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [31:0]           result
);

   localparam int unsigned NI  = DIGITS - RADIX - 1;
   localparam int unsigned NIW = (NI > 0) ? NI : 1;
   localparam int unsigned VW  = 32 + FBITS;
   localparam int unsigned CW  = $clog2(FBITS + NIW + 1);
   localparam int unsigned PW  = $clog2(VW);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INT,
      S_FRAC,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [4*NIW-1:0]    r_int_bcd;
   logic [4*RADIX-1:0]  r_frac_bcd;
   logic [31:0]         r_iacc;
   logic [FBITS-1:0]    r_facc;
   logic [CW-1:0]       r_cnt;
   logic                r_sign;
   logic                r_zero;
   logic [VW-1:0]       r_norm;
   logic [7:0]          r_exp;
   logic [31:0]         r_result;
   logic                r_err;

   logic                w_bad;
   logic [3:0]          w_dig;
   logic [31:0]         w_iacc_next;
   logic [4*RADIX-1:0]  w_frac_dbl;
   logic                w_frac_carry;
   logic [4:0]          w_t;
   logic                w_c;
   logic [VW-1:0]       w_v;
   logic                w_vz;
   logic [PW-1:0]       w_p;
   logic [PW-1:0]       w_sh;
   logic [22:0]         w_mant;
   logic                w_g;
   logic                w_s;
   logic                w_up;
   logic [23:0]         w_msum;
   logic [7:0]          w_exp_f;

   // Flag any digit outside 0..9, skipping the separator slot
   always_comb begin
      w_bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (i != RADIX && bcd_in[4*i +: 4] > 4'd9) begin
            w_bad = 1'b1;
         end
      end
   end

   // Integer fold: iacc*10 + next digit
   always_comb begin
      w_dig       = r_int_bcd[4*NIW-1 -: 4];
      w_iacc_next = (r_iacc << 3) + (r_iacc << 1) + {28'd0, w_dig};
   end

   // Decimal doubling of the fraction digits; the carry out of the top
   // fraction digit is the next binary fraction bit
   always_comb begin
      w_frac_dbl = '0;
      w_t        = '0;
      w_c        = 1'b0;
      for (int unsigned i = 0; i < RADIX; i++) begin
         w_t = {r_frac_bcd[4*i +: 4], 1'b0} + {4'd0, w_c};
         if (w_t >= 5'd10) begin
            w_frac_dbl[4*i +: 4] = w_t[3:0] + 4'd6;
            w_c                  = 1'b1;
         end else begin
            w_frac_dbl[4*i +: 4] = w_t[3:0];
            w_c                  = 1'b0;
         end
      end
      w_frac_carry = w_c;
   end

   // Leading-one detect over the fixed-point value
   always_comb begin
      w_v  = {r_iacc, r_facc};
      w_vz = (w_v == '0);
      w_p  = '0;
      for (int unsigned i = 0; i < VW; i++) begin
         if (w_v[i]) begin
            w_p = PW'(i);
         end
      end
      w_sh = PW'(VW - 1) - w_p;
   end

   // Round-to-nearest-even on the normalised value
   always_comb begin
      w_mant  = r_norm[VW-2 -: 23];
      w_g     = r_norm[VW-25];
      w_s     = |r_norm[VW-26:0];
      w_up    = w_g & (w_s | w_mant[0]);
      w_msum  = {1'b0, w_mant} + {23'd0, w_up};
      w_exp_f = r_exp + {7'd0, w_msum[23]};
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      w_next = r_state;
      ready  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               if (w_bad) begin
                  w_next = S_DONE;
               end else if (NI > 0) begin
                  w_next = S_INT;
               end else begin
                  w_next = S_FRAC;
               end
            end
         end
         S_INT: begin
            busy = 1'b1;
            if (r_cnt == CW'(NIW - 1)) begin
               w_next = S_FRAC;
            end
         end
         S_FRAC: begin
            busy = 1'b1;
            if (r_cnt == CW'(FBITS - 1)) begin
               w_next = S_NORM;
            end
         end
         S_NORM: begin
            busy   = 1'b1;
            w_next = S_ROUND;
         end
         S_ROUND: begin
            busy   = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            ready  = 1'b1;
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_int_bcd  <= '0;
         r_frac_bcd <= '0;
         r_iacc     <= '0;
         r_facc     <= '0;
         r_cnt      <= '0;
         r_sign     <= 1'b0;
         r_zero     <= 1'b0;
         r_norm     <= '0;
         r_exp      <= '0;
         r_result   <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sign     <= sign;
                  r_int_bcd  <= bcd_in[4*DIGITS-1 -: 4*NIW];
                  r_frac_bcd <= bcd_in[4*RADIX-1:0];
                  r_iacc     <= '0;
                  r_facc     <= '0;
                  r_cnt      <= '0;
                  if (w_bad) begin
                     r_err    <= 1'b1;
                     r_result <= 32'h7FC0_0000;
                  end
               end
            end
            S_INT: begin
               r_iacc    <= w_iacc_next;
               r_int_bcd <= r_int_bcd << 4;
               if (r_cnt == CW'(NIW - 1)) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_FRAC: begin
               r_frac_bcd <= w_frac_dbl;
               r_facc     <= {r_facc[FBITS-2:0], w_frac_carry};
               r_cnt      <= r_cnt + 1'b1;
            end
            S_NORM: begin
               r_zero <= w_vz;
               r_norm <= w_v << w_sh;
               r_exp  <= 8'(int'(w_p) + 127 - int'(FBITS));
            end
            S_ROUND: begin
               r_err <= 1'b0;
               if (r_zero) begin
                  r_result <= {r_sign, 31'd0};
               end else begin
                  r_result <= {r_sign, w_exp_f, w_msum[22:0]};
               end
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;
   assign err    = r_err;

endmodule

// File: tb/tb_bcd2f32.sv
// Directed bench for bcd2f32: hand-computed float32 results, latency,
// handshake, invalid digits, start-while-busy and mid-conversion reset.
module tb_bcd2f32;

   logic        clk;
   logic        reset;
   logic        start;
   logic        sign;
   logic [39:0] bcd_in;
   logic        ready;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] result;

   int n_err;
   int n_chk;

   bcd2f32 #(.DIGITS(10), .RADIX(8), .FBITS(56)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .sign   (sign),
      .bcd_in (bcd_in),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .result (result)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Layout of bcd: {int digit, separator, 8 fraction digits MSB first}.
   // poke_at > 0 pulses start again in that cycle of the conversion.
   task automatic convert(input string tag, input logic [39:0] bcd, input logic s,
                          input logic [31:0] exp_res, input logic exp_err,
                          input int exp_cyc, input int poke_at);
      int cyc;
      int extra;
      @(negedge clk);
      start  = 1'b1;
      bcd_in = bcd;
      sign   = s;
      @(posedge clk);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (poke_at > 0 && cyc == poke_at) begin
            start  = 1'b1;
            bcd_in = 40'h0F1000_0000;
            sign   = ~s;
         end else begin
            start = 1'b0;
         end
         if (cyc == 1 && exp_cyc > 1) begin
            check({tag, ".busy1"}, {31'd0, busy}, 32'd1);
            check({tag, ".ready1"}, {31'd0, ready}, 32'd0);
         end
      end while (!done && cyc < 200);
      start = 1'b0;
      check({tag, ".cycle"}, cyc, exp_cyc);
      check({tag, ".result"}, result, exp_res);
      check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
      check({tag, ".ready_done"}, {31'd0, ready}, 32'd1);
      if (poke_at > 0) begin
         extra = 0;
         repeat (80) begin
            @(negedge clk);
            if (done) extra++;
         end
         check({tag, ".extra_done"}, extra, 0);
         check({tag, ".result_hold"}, result, exp_res);
      end
   endtask

   initial begin
      int n_done;
      n_err  = 0;
      n_chk  = 0;
      reset  = 1'b1;
      start  = 1'b0;
      sign   = 1'b0;
      bcd_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst.ready", {31'd0, ready}, 32'd1);
      check("rst.busy", {31'd0, busy}, 32'd0);
      check("rst.done", {31'd0, done}, 32'd0);
      check("rst.err", {31'd0, err}, 32'd0);
      check("rst.result", result, 32'h0);

      convert("p1_5",     40'h1F5000_0000, 1'b0, 32'h3FC0_0000, 1'b0, 60, 0);
      convert("p0_1",     40'h0F1000_0000, 1'b0, 32'h3DCC_CCCD, 1'b0, 60, 0);
      convert("p9_99",    40'h9F9999_9999, 1'b0, 32'h4120_0000, 1'b0, 60, 0);
      convert("p1e-8",    40'h0F0000_0001, 1'b0, 32'h322B_CC77, 1'b0, 60, 0);
      convert("n0",       40'h0F0000_0000, 1'b1, 32'h8000_0000, 1'b0, 60, 0);
      convert("n0_5",     40'h0F5000_0000, 1'b1, 32'hBF00_0000, 1'b0, 60, 0);
      convert("p0_75",    40'h0F7500_0000, 1'b0, 32'h3F40_0000, 1'b0, 60, 0);
      convert("p0_25",    40'h0F2500_0000, 1'b0, 32'h3E80_0000, 1'b0, 60, 0);
      convert("p9",       40'h9F0000_0000, 1'b0, 32'h4110_0000, 1'b0, 60, 0);
      convert("p5_sep0",  40'h500000_0000, 1'b0, 32'h40A0_0000, 1'b0, 60, 0);
      convert("bad_d3",   40'h0F0000_A000, 1'b1, 32'h7FC0_0000, 1'b1, 1, 0);
      convert("clr_err",  40'h1F5000_0000, 1'b0, 32'h3FC0_0000, 1'b0, 60, 0);
      convert("bad_int",  40'hBF0000_0000, 1'b0, 32'h7FC0_0000, 1'b1, 1, 0);
      convert("poke20",   40'h1F5000_0000, 1'b0, 32'h3FC0_0000, 1'b0, 60, 20);

      // Reset in cycle 30 of a conversion, with start raised alongside it
      @(negedge clk);
      start  = 1'b1;
      bcd_in = 40'h0F1000_0000;
      sign   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      check("midrst.ready", {31'd0, ready}, 32'd1);
      check("midrst.busy", {31'd0, busy}, 32'd0);
      check("midrst.done", {31'd0, done}, 32'd0);
      check("midrst.err", {31'd0, err}, 32'd0);
      check("midrst.result", result, 32'h0);
      n_done = 0;
      repeat (80) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("midrst.no_done", n_done, 0);
      convert("after_rst", 40'h0F1000_0000, 1'b0, 32'h3DCC_CCCD, 1'b0, 60, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
